// File: rtl/dram_pkg.sv
// Shared types, default timing and command decode for the DRAM pin-level responder.
package dram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_RD,
        CMD_WR,
        CMD_ILL
    } dram_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVATING,
        ACTIVE,
        PRECHARGING
    } dram_state_e;

    localparam int DEF_ROW_BITS = 11;
    localparam int DEF_COL_BITS = 10;
    localparam int DEF_T_RCD    = 5;
    localparam int DEF_T_RP     = 5;
    localparam int DEF_CL       = 5;

    // WEn doubles as the ACT/PRE and RD/WR discriminator.
    function automatic dram_cmd_e decode_cmd(input logic       csn,
                                             input logic       rasn,
                                             input logic       casn,
                                             input logic [3:0] wen);
        dram_cmd_e cmd;
        cmd = CMD_NOP;
        if (!csn) begin
            case ({rasn, casn})
                2'b01:   cmd = (wen == 4'hF) ? CMD_ACT : CMD_PRE;
                2'b10:   cmd = (wen == 4'hF) ? CMD_RD  : CMD_WR;
                2'b00:   cmd = CMD_ILL;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// CL-stage read-return pipe: VALID pulses once per pushed read, Q holds the last returned word.
module dram_rd_pipe #(
    parameter int CL = 5,
    parameter int W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [CL-1:0] vld_q;
    logic [W-1:0]  dat_q [CL];

    // Data stages only load behind a valid bit, so the last stage holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < CL; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= push_i;
            if (push_i) dat_q[0] <= data_i;
            for (int i = 1; i < CL; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[CL-1];
    assign data_o  = dat_q[CL-1];

endmodule

// File: rtl/dram_responder.sv
// DRAM device-side responder: ACT/PRE/RD/WR decode, tRCD/tRP enforcement,
// word storage organised as rows x columns, CL-latency read return and sticky ERR.
module dram_responder
    import dram_pkg::*;
#(
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RP     = DEF_T_RP,
    parameter int CL       = DEF_CL
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        ERR
);

    localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W  = $clog2(T_MAX + 1);
    localparam int ADDR_W = ROW_BITS + COL_BITS;

    dram_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                err_q, err_d;
    dram_cmd_e           cmd;
    logic                rd_en, wr_en;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         rd_data;
    logic [31:0]         mem_q [2**ADDR_W];

    assign addr    = {row_q, A[COL_BITS-1:0]};
    assign rd_data = mem_q[addr];

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        cmd     = decode_cmd(CSn, RASn, CASn, WEn);
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;

        if (cmd == CMD_ILL) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                case (cmd)
                    CMD_ACT: begin
                        row_d = A[ROW_BITS-1:0];
                        if (T_RCD <= 1) begin
                            state_d = ACTIVE;
                        end else begin
                            state_d = ACTIVATING;
                            cnt_d   = CNT_W'(T_RCD - 1);
                        end
                    end
                    CMD_PRE, CMD_RD, CMD_WR: err_d = 1'b1;
                    default: ;
                endcase
            end
            ACTIVATING: begin
                // Counter hits zero on the edge before the first legal RD/WR.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = ACTIVE;
                case (cmd)
                    CMD_PRE: begin
                        if (T_RP <= 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = PRECHARGING;
                            cnt_d   = CNT_W'(T_RP - 1);
                        end
                    end
                    CMD_ACT, CMD_RD, CMD_WR: err_d = 1'b1;
                    default: ;
                endcase
            end
            ACTIVE: begin
                case (cmd)
                    CMD_RD:  rd_en = 1'b1;
                    CMD_WR:  wr_en = 1'b1;
                    CMD_ACT: err_d = 1'b1;
                    CMD_PRE: begin
                        if (T_RP <= 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = PRECHARGING;
                            cnt_d   = CNT_W'(T_RP - 1);
                        end
                    end
                    default: ;
                endcase
            end
            PRECHARGING: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = IDLE;
                if (cmd != CMD_NOP) err_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; only control state is cleared.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEn[i]) mem_q[addr][8*i +: 8] <= D[8*i +: 8];
            end
        end
    end

    dram_rd_pipe #(
        .CL (CL),
        .W  (32)
    ) u_rd_pipe (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .push_i  (rd_en),
        .data_i  (rd_data),
        .valid_o (VALID),
        .data_o  (Q)
    );

    assign ERR = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: inputs change and outputs are sampled on the falling edge.
module tb_dram_responder;

    localparam int CL = 5;

    logic        ACLK;
    logic        ARESETn;
    logic        CSn;
    logic        RASn;
    logic        CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    dram_responder u_dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .CSn     (CSn),
        .RASn    (RASn),
        .CASn    (CASn),
        .WEn     (WEn),
        .A       (A),
        .D       (D),
        .Q       (Q),
        .VALID   (VALID),
        .ERR     (ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic csn, input logic rasn, input logic casn,
                         input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
        @(negedge ACLK);
        CSn  = csn;
        RASn = rasn;
        CASn = casn;
        WEn  = wen;
        A    = a;
        D    = d;
    endtask

    task automatic nop();                    drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0); endtask
    task automatic act(input logic [10:0] r); drive(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);   endtask
    task automatic pre();                    drive(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0); endtask
    task automatic rd(input logic [10:0] c);  drive(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0);   endtask
    task automatic ill();                    drive(1'b0, 1'b0, 1'b0, 4'hF, 11'h0, 32'h0); endtask
    task automatic wr(input logic [10:0] c, input logic [31:0] d, input logic [3:0] wen);
        drive(1'b0, 1'b1, 1'b0, wen, c, d);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // Called right after rd(): VALID must stay low CL-1 cycles, then pulse once with the data.
    task automatic read_check(input string tag, input logic [31:0] exp);
        nops(CL - 1);
        check({tag, "_vld_early"}, VALID, 1'b0);
        nop();
        check({tag, "_vld"}, VALID, 1'b1);
        check({tag, "_q"}, Q, exp);
    endtask

    initial begin
        int seen_valid;
        ARESETn = 1'b0;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;

        // Reset values, then single write/read.
        do_reset();
        check("rst_q", Q, 32'h0);
        check("rst_valid", VALID, 1'b0);
        check("rst_err", ERR, 1'b0);
        act(11'h012);
        nops(4);
        wr(11'h034, 32'hDEADBEEF, 4'h0);
        rd(11'h034);
        read_check("single", 32'hDEADBEEF);
        nop();
        check("single_vld_off", VALID, 1'b0);
        check("single_q_hold", Q, 32'hDEADBEEF);
        check("single_err", ERR, 1'b0);

        // Byte-masked write; a WR right after an RD must not alter that RD's data.
        wr(11'h040, 32'h11223344, 4'b0000);
        wr(11'h040, 32'hAABBCCDD, 4'b1010);
        rd(11'h040);
        wr(11'h040, 32'h55555555, 4'b0000);
        nops(3);
        nop();
        check("partial_vld", VALID, 1'b1);
        check("partial_q", Q, 32'h11BB33DD);
        rd(11'h040);
        read_check("overwrite", 32'h55555555);

        // Four back-to-back reads then PRE: all four return in order.
        for (int i = 0; i < 4; i++) wr(11'(i), 32'hA0 + 32'(i), 4'h0);
        for (int i = 0; i < 4; i++) rd(11'(i));
        pre();
        for (int i = 0; i < 4; i++) begin
            nop();
            check($sformatf("pipe%0d_vld", i), VALID, 1'b1);
            check($sformatf("pipe%0d_q", i), Q, 32'hA0 + 32'(i));
        end
        nop();
        check("pipe_vld_off", VALID, 1'b0);
        check("pipe_err", ERR, 1'b0);

        // RD inside tRCD flags ERR and never returns; RD at tRCD does.
        do_reset();
        act(11'h012);
        nops(2);
        rd(11'h034);
        nop();
        check("early_err", ERR, 1'b1);
        rd(11'h034);
        nops(3);
        check("early_no_vld", VALID, 1'b0);
        nops(2);
        check("late_vld", VALID, 1'b1);
        check("late_q", Q, 32'hDEADBEEF);
        check("early_err_sticky", ERR, 1'b1);

        // ACT one cycle inside tRP is rejected; ACT at tRP opens the new row.
        do_reset();
        act(11'h007);
        nops(4);
        wr(11'h005, 32'h77777777, 4'h0);
        pre();
        nops(4);
        act(11'h009);
        nops(4);
        wr(11'h005, 32'h99999999, 4'h0);
        pre();
        nops(3);
        check("trp_err_before", ERR, 1'b0);
        act(11'h009);
        act(11'h007);
        check("trp_err_early", ERR, 1'b1);
        nops(4);
        rd(11'h005);
        read_check("trp_row", 32'h77777777);

        // Reset while a read is in flight drops it.
        do_reset();
        act(11'h012);
        nops(4);
        rd(11'h034);
        read_check("prerst", 32'hDEADBEEF);
        rd(11'h034);
        ill();
        @(negedge ACLK);
        check("ill_err", ERR, 1'b1);
        ARESETn = 1'b0;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
        #1;
        check("midrst_valid", VALID, 1'b0);
        check("midrst_q", Q, 32'h0);
        check("midrst_err", ERR, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < CL + 3; i++) begin
            nop();
            if (VALID === 1'b1) seen_valid++;
        end
        check("midrst_no_stray", 32'(seen_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
